axi_read_stream: RTL and testbench
==================================

Name: axi_read_stream

Overview:
- Parametrised AXI4 read master feeding an AXI-Stream source; successor to the fixed 32-bit-read / 8-bit-stream test top.
- On start, reads num_beats words from base_addr using INCR bursts no longer than MAX_BURST beats, split at 4 KB boundaries.
- Buffers each returned word and serialises it into STREAM_WIDTH lanes, least-significant lane first.
- Sits between axi_ram (or any AXI4 slave) and downstream stream consumers.

Parameters:
- DATA_WIDTH, 32: AXI data width in bits.
- ADDR_WIDTH, 16: AXI address width.
- ID_WIDTH, 8: ARID/RID width; ARID is driven to 0.
- STREAM_WIDTH, 8: tdata width. DATA_WIDTH must be an integer multiple of STREAM_WIDTH.
- MAX_BURST, 16: maximum beats per burst, 1..256.
- LEN_WIDTH, 16: width of num_beats.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a transfer; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address, aligned to DATA_WIDTH/8; captured on start
- num_beats  in  LEN_WIDTH  number of words to read; captured on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of transfer
- error  out  1  sticky; set on any rresp!=0; cleared on start
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats-1
- m_axi_arsize  out  3  log2(DATA_WIDTH/8)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arlock  out  1  constant 0
- m_axi_arcache  out  4  constant 0
- m_axi_arprot  out  3  constant 0
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_rid  in  ID_WIDTH  ignored
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- m_axis_tdata  out  STREAM_WIDTH  stream data
- m_axis_tlast  out  1  final lane of final word
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready

Behaviour:
- Reset values:
  - Outputs: busy, done, error, arvalid, rready, tvalid and tlast are 0; araddr and arlen are 0; tdata is 0.
  - Internal state: state=IDLE, lane=0, word buffer empty.
- Reset is honoured mid-operation: all state is abandoned immediately and no outstanding R beats are tracked afterwards.
- States and transitions:
  - IDLE: start with num_beats==0 → DONE, no AR issued. Start with num_beats>0 → capture inputs, clear error → ADDR.
  - ADDR: arvalid=1; araddr=cur_addr; arlen=blen-1.
    - blen = min(remaining, MAX_BURST, (4096 - cur_addr[11:0]) / (DATA_WIDTH/8)).
    - araddr and arlen are held stable while arvalid=1 and arready=0.
    - On handshake: cur_addr += blen*(DATA_WIDTH/8), remaining -= blen, arvalid drops the next cycle → DATA.
  - DATA: accept R beats. On an accepted beat with rlast=1:
    - remaining>0 → ADDR.
    - remaining==0 → stay in DATA until the final lane handshakes on the stream, then → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Outstanding bursts: exactly one at a time. The next AR is issued only after the previous burst's rlast beat is accepted.
- Buffer:
  - One DATA_WIDTH word register plus a lane counter, N = DATA_WIDTH/STREAM_WIDTH lanes.
  - tdata = buf[lane*STREAM_WIDTH +: STREAM_WIDTH].
  - tvalid = buffer full.
  - On a tready handshake, lane increments. On the last lane, the buffer empties and lane returns to 0.
- rready (combinational): (state==DATA) && (buffer empty || (tvalid && tready && lane==N-1)).
  - Back-to-back words therefore stream without bubbles.
  - rvalid is ignored outside DATA.
- tlast = tvalid && last lane && buffered word is the final word of the whole transfer. It is not asserted per burst.
- tdata, tlast and tvalid hold stable while tvalid && !tready.
- error: set on any accepted beat with rresp!=0. The data is still forwarded and the transfer completes normally.
- busy is 1 in ADDR and DATA. start is ignored when not in IDLE.

Test Plan:
- base_addr=0, num_beats=1, RAM word 0x44332211, tready=1 → one AR (araddr=0, arlen=0, arsize=2); tdata sequence 0x11,0x22,0x33,0x44; tlast only on 0x44; done pulse 1 cycle later.
- num_beats=20, MAX_BURST=16, base_addr=0x0100 → AR1 araddr=0x0100 arlen=15, AR2 araddr=0x0140 arlen=3; 80 stream bytes in address order; exactly one tlast.
- base_addr=0x0FF8, num_beats=4 → AR araddr=0x0FF8 arlen=1, then AR araddr=0x1000 arlen=1; data continuous across the 4 KB boundary.
- tready toggled pseudo-randomly, slave inserts rvalid gaps → no data lost or duplicated; rready never 1 while buffer full and not draining; tdata stable during stalls.
- Slave returns rresp=2'b10 on beat 2 of 3 → error=1 after that beat; all 12 bytes delivered; done pulses; next start clears error.
- num_beats=0 → no arvalid; done one cycle after DONE entry.
- Reset asserted mid-burst → next cycle all outputs at reset values; new start then completes a 2-word read correctly.

Source files
------------

// File: rtl/axi_read_stream.sv
// axi_read_stream: AXI4 read master that serialises returned words into an AXI-Stream, LSB lane first.
module axi_read_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 8,
  parameter int STREAM_WIDTH = 8,
  parameter int MAX_BURST    = 16,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    num_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int N = DATA_WIDTH / STREAM_WIDTH;
  localparam int LW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] word;
  logic [LW-1:0] lane;
  logic full, final_word, last_lane, ar_hs, r_hs, t_hs;
  logic [31:0] rem32, bnd, blen_a, blen;
  logic unused;
  assign unused = ^m_axi_rid;
  assign m_axi_arid = '0;
  assign m_axi_arsize = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot = '0;
  // Burst length: limited by words left, MAX_BURST and the distance to the next 4 KB page
  assign rem32 = 32'(remaining);
  assign bnd = (32'd4096 - 32'(cur_addr[11:0])) / 32'(BYTES);
  assign blen_a = rem32 < 32'(MAX_BURST) ? rem32 : 32'(MAX_BURST);
  assign blen = blen_a < bnd ? blen_a : bnd;
  assign last_lane = lane == LW'(N - 1);
  assign m_axis_tvalid = full;
  assign m_axis_tdata = word[lane*STREAM_WIDTH +: STREAM_WIDTH];
  assign m_axis_tlast = full && last_lane && final_word;
  assign t_hs = m_axis_tvalid && m_axis_tready;
  // A new word may land in the same cycle the last lane of the old one drains
  assign m_axi_rready = state == DATA && (!full || (t_hs && last_lane));
  assign r_hs = m_axi_rvalid && m_axi_rready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (start) next = num_beats == '0 ? DONE : ADDR;
      ADDR: if (ar_hs) next = DATA;
      DATA:
        if (r_hs && m_axi_rlast && remaining != '0) next = ADDR;
        else if (m_axis_tlast && m_axis_tready) next = DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = state == ADDR || state == DATA;
    done = state == DONE;
    m_axi_arvalid = state == ADDR;
    m_axi_araddr = m_axi_arvalid ? cur_addr : '0;
    m_axi_arlen = m_axi_arvalid ? 8'(blen - 32'd1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= '0;
      remaining <= '0;
      error <= 1'b0;
      word <= '0;
      lane <= '0;
      full <= 1'b0;
      final_word <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr <= base_addr;
        remaining <= num_beats;
        error <= 1'b0;
      end
      if (ar_hs) begin
        cur_addr <= cur_addr + ADDR_WIDTH'(blen * 32'(BYTES));
        remaining <= remaining - LEN_WIDTH'(blen);
      end
      if (r_hs && m_axi_rresp != 2'b00) error <= 1'b1;
      if (r_hs) begin
        word <= m_axi_rdata;
        full <= 1'b1;
        lane <= '0;
        final_word <= m_axi_rlast && remaining == '0;
      end else if (t_hs) begin
        full <= !last_lane;
        lane <= last_lane ? '0 : lane + LW'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi_read_stream.sv
// tb_axi_read_stream: scoreboard bench with a one-outstanding AXI slave model and random stalls.
module tb_axi_read_stream;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] base_addr = 0, num_beats = 0;
  logic busy, done, error;
  logic [7:0] arid, arlen, tdata;
  logic [15:0] araddr;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, rresp = 0;
  logic arlock, arvalid, arready = 0, rlast = 0, rvalid = 0, rready, tlast, tvalid, tready = 0;
  logic [3:0] arcache;
  logic [7:0] rid = 0;
  logic [31:0] rdata = 0;
  always #5 clk = ~clk;
  axi_read_stream #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .STREAM_WIDTH(8),
    .MAX_BURST(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );
  int n_tests = 0, n_fail = 0, cyc = 0, done_cyc = 0, tlast_cyc = 0, n_done = 0, n_tlast = 0;
  int beat_idx = 0, err_beat = -1, t_lane = 0, b_left = 0;
  logic b_active = 0, r_taken = 0, rnd = 0, exp_err = 0, prev_tstall = 0, prev_arstall = 0, prev_tlast = 0;
  logic [7:0] prev_tdata = 0, prev_arlen = 0;
  logic [15:0] prev_araddr = 0, b_addr = 0;
  logic [23:0] ar_q[$];
  logic [8:0] s_q[$];
  logic [31:0] mem [0:16383];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drives the slave/sink at the falling edge, then scores the handshakes the next rising edge will take
  task automatic tick();
    logic [23:0] ea;
    logic [8:0] es;
    @(negedge clk);
    start = 0;
    cyc++;
    if (rst) begin
      rvalid = 0; arready = 0; tready = 0;
      #1;
      check("rst_outs", 64'({busy, done, error, arvalid, rready, tvalid, tlast, araddr, arlen, tdata}), 0);
      ar_q.delete(); s_q.delete();
      b_active = 0; r_taken = 0; exp_err = 0; t_lane = 0; prev_tstall = 0; prev_arstall = 0;
      rst = 0;
      return;
    end
    if (r_taken) begin rvalid = 0; r_taken = 0; end
    if (!rvalid && b_active && b_left > 0 && (!rnd || $urandom_range(3) != 0)) begin
      rdata = mem[b_addr[15:2]];
      rlast = b_left == 1;
      rresp = beat_idx == err_beat ? 2'b10 : 2'b00;
      rvalid = 1;
    end
    arready = !rnd || $urandom_range(1) == 1;
    tready = !rnd || $urandom_range(2) != 0;
    #1;
    check("error", error, exp_err);
    if (prev_tstall) check("t_hold", {tvalid, tlast, tdata}, {1'b1, prev_tlast, prev_tdata});
    if (prev_arstall) check("ar_hold", {arvalid, araddr, arlen}, {1'b1, prev_araddr, prev_arlen});
    if (rready && tvalid) check("rready_drain", {tready, t_lane == 3}, 2'b11);
    if (arvalid && arready) begin
      check("ar_while_busy", b_active, 0);
      check("ar_expected", ar_q.size() > 0, 1);
      check("arsize", {arburst, arsize}, {2'b01, 3'd2});
      if (ar_q.size() > 0) begin
        ea = ar_q.pop_front();
        check("ar", {araddr, arlen}, ea);
      end
      b_active = 1; b_addr = araddr; b_left = int'(arlen) + 1;
    end
    if (rvalid && rready) begin
      if (rresp != 0) exp_err = 1;
      b_addr += 4; b_left--; beat_idx++; r_taken = 1;
      if (b_left == 0) b_active = 0;
    end
    if (tvalid && tready) begin
      check("s_expected", s_q.size() > 0, 1);
      if (s_q.size() > 0) begin
        es = s_q.pop_front();
        check("stream", {tlast, tdata}, es);
      end
      t_lane = (t_lane + 1) % 4;
      if (tlast) begin n_tlast++; tlast_cyc = cyc; end
    end
    if (done) begin n_done++; done_cyc = cyc; end
    prev_tstall = tvalid && !tready; prev_tlast = tlast; prev_tdata = tdata;
    prev_arstall = arvalid && !arready; prev_araddr = araddr; prev_arlen = arlen;
  endtask
  task automatic launch(input logic [15:0] base, input int n, input int eb, input logic r);
    logic [15:0] a;
    logic [31:0] w;
    logic lst;
    int rem, bl, room;
    a = base; rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      bl = rem > 16 ? 16 : rem;
      if (bl > room) bl = room;
      ar_q.push_back({a, 8'(bl - 1)});
      a += 16'(bl * 4);
      rem -= bl;
    end
    for (int i = 0; i < n; i++) begin
      w = mem[int'(base >> 2) + i];
      for (int k = 0; k < 4; k++) begin
        lst = i == n - 1 && k == 3;
        s_q.push_back({lst, w[8*k +: 8]});
      end
    end
    err_beat = eb; beat_idx = 0; rnd = r; n_tlast = 0; n_done = 0; done_cyc = 0; tlast_cyc = -100;
    base_addr = base; num_beats = 16'(n); start = 1; exp_err = 0;
  endtask
  task automatic run_xfer(input logic [15:0] base, input int n, input int eb, input logic r);
    int s;
    launch(base, n, eb, r);
    s = cyc;
    tick();
    check("busy", busy, n > 0);
    for (int k = 0; k < 4000 && done_cyc == 0; k++) tick();
    check("done_seen", done_cyc != 0, 1);
    check("done_time", done_cyc, n > 0 ? tlast_cyc + 1 : s + 1);
    tick();
    check("done_pulse", {n_done, busy, done}, {32'd1, 2'b00});
    check("ar_left", ar_q.size(), 0);
    check("s_left", s_q.size(), 0);
    check("tlast_count", n_tlast, n > 0);
    check("error_final", error, eb >= 0 && eb < n);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    mem[0] = 32'h44332211;
    tick();
    run_xfer(16'h0000, 1, -1, 0);
    run_xfer(16'h0100, 20, -1, 0);
    run_xfer(16'h0FF8, 4, -1, 0);
    run_xfer(16'h0200, 37, -1, 1);
    run_xfer(16'h0FC0, 40, -1, 1);
    run_xfer(16'h0300, 3, 1, 0);
    run_xfer(16'h0400, 2, -1, 0);
    run_xfer(16'h0700, 0, -1, 0);
    launch(16'h0500, 20, -1, 0);
    repeat (12) tick();
    rst = 1;
    tick();
    run_xfer(16'h0600, 2, -1, 0);
    run_xfer(16'h2000, 25, 3, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
